// File: rtl/ksa32_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: diff = a - b - bin with borrow and status flags.
// Stage 1 runs the first SPLIT prefix levels, stage 2 the rest plus sum and flags.
module ksa32_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    logic v0, v1, v2;
    logic en0, en1, en2;

    // Each stage advances independently so empty slots collapse under an output stall.
    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign en0       = !v0 || en1;
    assign in_ready  = en0;
    assign out_valid = v2;

    // Stage 0: propagate/generate of a + ~b + ~bin
    logic [WIDTH-1:0] p0_q, g0_q;
    logic             cin0_q, a_msb0_q, b_msb0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers only need their valid bit reset; they are cleared too so waveforms stay deterministic.
            v0       <= 1'b0;
            p0_q     <= '0;
            g0_q     <= '0;
            cin0_q   <= 1'b0;
            a_msb0_q <= 1'b0;
            b_msb0_q <= 1'b0;
        end else if (en0) begin
            v0 <= in_valid;
            if (in_valid) begin
                p0_q     <= a ^ ~b;
                g0_q     <= a & ~b;
                cin0_q   <= ~bin;
                a_msb0_q <= a[WIDTH-1];
                b_msb0_q <= b[WIDTH-1];
            end
        end
    end

    logic [WIDTH-1:0] g_init;
    assign g_init = g0_q | {{(WIDTH-1){1'b0}}, p0_q[0] & cin0_q};

    for (genvar k = 0; k < SPLIT; k++) begin : g_lv1
        localparam int D = 1 << k;
        localparam logic [WIDTH-1:0] LOW = (WIDTH'(1) << D) - WIDTH'(1);
        logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
        if (k == 0) begin : g_first
            assign g_in = g_init;
            assign p_in = p0_q;
        end else begin : g_next
            assign g_in = g_lv1[k-1].g_out;
            assign p_in = g_lv1[k-1].p_out;
        end
        assign g_out = g_in | (p_in & (g_in << D));
        assign p_out = p_in & ((p_in << D) | LOW);
    end

    // Stage 1: partial group G/P plus the bit-level p needed for the final sum
    logic [WIDTH-1:0] g1_q, p1_q, po1_q;
    logic             cin1_q, a_msb1_q, b_msb1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            g1_q     <= '0;
            p1_q     <= '0;
            po1_q    <= '0;
            cin1_q   <= 1'b0;
            a_msb1_q <= 1'b0;
            b_msb1_q <= 1'b0;
        end else if (en1) begin
            v1 <= v0;
            if (v0) begin
                g1_q     <= g_lv1[SPLIT-1].g_out;
                p1_q     <= g_lv1[SPLIT-1].p_out;
                po1_q    <= p0_q;
                cin1_q   <= cin0_q;
                a_msb1_q <= a_msb0_q;
                b_msb1_q <= b_msb0_q;
            end
        end
    end

    for (genvar j = 0; j < LEVELS - SPLIT; j++) begin : g_lv2
        localparam int D = 1 << (SPLIT + j);
        localparam logic [WIDTH-1:0] LOW = (WIDTH'(1) << D) - WIDTH'(1);
        logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
        if (j == 0) begin : g_first
            assign g_in = g1_q;
            assign p_in = p1_q;
        end else begin : g_next
            assign g_in = g_lv2[j-1].g_out;
            assign p_in = g_lv2[j-1].p_out;
        end
        assign g_out = g_in | (p_in & (g_in << D));
        assign p_out = p_in & ((p_in << D) | LOW);
    end

    logic [WIDTH-1:0] g_fin, sum_n;
    logic             unused_p;

    assign g_fin    = g_lv2[LEVELS-SPLIT-1].g_out;
    assign unused_p = ^g_lv2[LEVELS-SPLIT-1].p_out;
    // Carry into bit i is the prefix generate of bits i-1..0 with carry-in already folded in.
    assign sum_n    = po1_q ^ {g_fin[WIDTH-2:0], cin1_q};

    // Stage 2: registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                diff   <= sum_n;
                borrow <= ~g_fin[WIDTH-1];
                zero   <= ~|sum_n;
                neg    <= sum_n[WIDTH-1];
                ovf    <= (a_msb1_q ^ b_msb1_q) & (sum_n[WIDTH-1] ^ a_msb1_q);
            end
        end
    end

endmodule
